// File: rtl/sequence_player.sv
// rtl/sequence_player.sv - Simon sequence storage and LED playback, paced by variable_delay
module sequence_player #(
  parameter int DEPTH = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       append,
  input  logic [1:0] append_color,
  input  logic       start,
  input  logic       delay_pulse,
  output logic       delay_reset,
  output logic [4:0] delay_index,
  output logic [3:0] led,
  output logic       busy,
  output logic       done,
  output logic [5:0] seq_len,
  output logic       full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ARM_ON, S_ON, S_ARM_OFF, S_OFF, S_DONE
  } state_t;

  state_t     state, state_next;
  logic [4:0] idx, idx_next;
  logic [1:0] mem [DEPTH];
  logic       append_ok;

  assign full      = (seq_len == 6'(DEPTH));
  assign append_ok = append && (state == S_IDLE) && !full;

  // Sequence contents survive reset; only the length is cleared.
  always_ff @(posedge clk) begin
    if (append_ok) mem[seq_len[AW-1:0]] <= append_color;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      idx         <= '0;
      seq_len     <= '0;
      delay_index <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (append_ok) begin
        seq_len     <= seq_len + 6'd1;
        delay_index <= seq_len[4:0];
      end
    end
  end

  always_comb begin
    state_next  = state;
    idx_next    = idx;
    delay_reset = 1'b1;
    led         = 4'b0000;
    busy        = 1'b1;
    done        = 1'b0;
    case (state)
      S_IDLE: begin
        busy = 1'b0;
        // A same-cycle append counts toward the length being played.
        if (start) begin
          if (seq_len != 6'd0 || append_ok) begin
            state_next = S_ARM_ON;
            idx_next   = '0;
          end else begin
            state_next = S_DONE;
          end
        end
      end
      S_ARM_ON: state_next = S_ON;
      S_ON: begin
        delay_reset = 1'b0;
        led         = 4'b0001 << mem[idx[AW-1:0]];
        if (delay_pulse) state_next = S_ARM_OFF;
      end
      S_ARM_OFF: state_next = S_OFF;
      S_OFF: begin
        delay_reset = 1'b0;
        if (delay_pulse) begin
          if ({1'b0, idx} == seq_len - 6'd1) begin
            state_next = S_DONE;
          end else begin
            idx_next   = idx + 5'd1;
            state_next = S_ARM_ON;
          end
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sequence_player.sv
// tb/tb_sequence_player.sv - randomized playback checks against a queue-based sequence model
module tb_sequence_player;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       append = 1'b0;
  logic [1:0] append_color = 2'd0;
  logic       start = 1'b0;
  logic       delay_pulse;
  logic       delay_reset;
  logic [4:0] delay_index;
  logic [3:0] led;
  logic       busy;
  logic       done;
  logic [5:0] seq_len;
  logic       full;

  sequence_player #(.DEPTH(32)) dut (
    .clk(clk), .reset(reset), .append(append), .append_color(append_color),
    .start(start), .delay_pulse(delay_pulse), .delay_reset(delay_reset),
    .delay_index(delay_index), .led(led), .busy(busy), .done(done),
    .seq_len(seq_len), .full(full)
  );

  always #5 clk = ~clk;

  // Stand-in for variable_delay: pulses pulse_n cycles after its reset drops; random noise while held in reset.
  int   pulse_n = 5;
  int   dcnt = 0;
  logic noise = 1'b0;
  always @(posedge clk) dcnt <= delay_reset ? 0 : dcnt + 1;
  always @(negedge clk) noise <= 1'($urandom_range(0, 1));
  assign delay_pulse = delay_reset ? noise : (dcnt == pulse_n - 1);

  int         n_checks = 0;
  int         n_pass = 0;
  logic [1:0] model[$];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_reset_values(input string tag);
    check({tag, "_led"}, led, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_seq_len"}, seq_len, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_delay_index"}, delay_index, 0);
    check({tag, "_delay_reset"}, delay_reset, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    append = 1'b0;
    start = 1'b0;
    tick();
    check_idle_reset_values("reset");
    reset = 1'b0;
    model.delete();
  endtask

  task automatic do_append(input logic [1:0] c);
    append = 1'b1;
    append_color = c;
    tick();
    append = 1'b0;
    if (model.size() < 32) model.push_back(c);
    check("append_seq_len", seq_len, model.size());
    check("append_full", full, (model.size() == 32) ? 1 : 0);
    check("append_delay_index", delay_index, (model.size() == 0) ? 0 : model.size() - 1);
  endtask

  task automatic play(input int n, input bit disturb, input bit with_append, input logic [1:0] c);
    int  exp_led[$];
    int  obs_led[$];
    int  busy_cnt;
    int  errs;
    bit  seen;
    busy_cnt = 0;
    errs = 0;
    seen = 1'b0;
    pulse_n = n;
    start = 1'b1;
    if (with_append) begin
      append = 1'b1;
      append_color = c;
    end
    tick();
    start = 1'b0;
    append = 1'b0;
    if (with_append && model.size() < 32) model.push_back(c);
    // Each step: arm cycle, n lit cycles, arm cycle, n dark cycles; then one done cycle.
    foreach (model[i]) begin
      exp_led.push_back(0);
      repeat (n) exp_led.push_back(1 << model[i]);
      exp_led.push_back(0);
      repeat (n) exp_led.push_back(0);
    end
    exp_led.push_back(0);
    for (int cyc = 0; cyc < 3000 && !seen; cyc++) begin
      obs_led.push_back(int'(led));
      if (busy) busy_cnt++;
      if (done) seen = 1'b1;
      if (disturb && cyc == 2) begin
        append = 1'b1;
        start = 1'b1;
        append_color = 2'($urandom);
      end else begin
        append = 1'b0;
        start = 1'b0;
      end
      if (!seen) tick();
    end
    append = 1'b0;
    start = 1'b0;
    check("done_seen", seen, 1);
    check("play_len", obs_led.size(), exp_led.size());
    for (int i = 0; i < obs_led.size() && i < exp_led.size(); i++)
      if (obs_led[i] != exp_led[i]) errs++;
    check("led_trace_errs", errs, 0);
    check("busy_cycles", busy_cnt, exp_led.size());
    tick();
    check("after_done_low", done, 0);
    check("after_busy_low", busy, 0);
    check("play_seq_len", seq_len, model.size());
    check("play_delay_index", delay_index, (model.size() == 0) ? 0 : model.size() - 1);
  endtask

  task automatic reset_mid_play();
    bit lit;
    lit = 1'b0;
    pulse_n = 4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && !lit; i++) begin
      if (led != 4'b0000) lit = 1'b1;
      else tick();
    end
    check("lit_before_reset", lit, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model.delete();
    check_idle_reset_values("midreset");
    repeat (3) begin
      tick();
      check("midreset_quiet", {led, done, busy}, 0);
    end
  endtask

  initial begin
    tick();
    do_reset();
    play(5, 0, 0, 2'd0);

    do_append(2'd2);
    play(5, 0, 0, 2'd0);

    do_reset();
    do_append(2'd0);
    do_append(2'd1);
    do_append(2'd3);
    play(3, 0, 0, 2'd0);

    do_reset();
    repeat (33) do_append(2'($urandom));
    play(1, 0, 0, 2'd0);

    do_reset();
    repeat (3) do_append(2'($urandom));
    play(4, 1, 0, 2'd0);

    reset_mid_play();
    play(3, 0, 0, 2'd0);

    do_reset();
    play(2, 0, 1, 2'($urandom));
    repeat (2) do_append(2'($urandom));
    play(2, 0, 1, 2'($urandom));

    for (int r = 0; r < 6; r++) begin
      if (r == 3) do_reset();
      repeat ($urandom_range(1, 6)) do_append(2'($urandom));
      play($urandom_range(1, 6), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
